// File: rtl/axi_lite_mem_slave.sv
// AXI4-Lite subordinate backed by a byte-strobed word RAM, serving one
// transaction at a time with configurable read/write response latency.
module axi_lite_mem_slave #(
  parameter int unsigned           DATA_WIDTH = 64,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DEPTH_LOG2 = 10,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
  parameter int unsigned           RD_LATENCY = 2,
  parameter int unsigned           WR_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   AXI_AWADDR,
  input  logic [2:0]              AXI_AWPROT,
  input  logic                    AXI_AWVALID,
  output logic                    AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]   AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0] AXI_WSTRB,
  input  logic                    AXI_WVALID,
  output logic                    AXI_WREADY,
  output logic [1:0]              AXI_BRESP,
  output logic                    AXI_BVALID,
  input  logic                    AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]   AXI_ARADDR,
  input  logic [2:0]              AXI_ARPROT,
  input  logic                    AXI_ARVALID,
  output logic                    AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]   AXI_RDATA,
  output logic [1:0]              AXI_RRESP,
  output logic                    AXI_RVALID,
  input  logic                    AXI_RREADY
);

  localparam int unsigned STRB_W    = DATA_WIDTH / 8;
  localparam int unsigned LANE_BITS = $clog2(STRB_W);
  localparam int unsigned CNT_W     = 16;
  localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'((64'(1) << DEPTH_LOG2) * STRB_W);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    WR_COLLECT,
    WR_LAT,
    WR_RESP,
    RD_LAT,
    RD_RESP
  } state_t;

  state_t state, state_next;

  logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];

  logic                  aw_got, w_got;
  logic [ADDR_WIDTH-1:0] awaddr_q, araddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]     wstrb_q;
  logic [CNT_W-1:0]      lat_cnt;

  logic aw_hs, w_hs, ar_hs, lat_zero, commit, rd_done;

  logic [ADDR_WIDTH-1:0] wr_off, rd_off;
  logic                  wr_ok, rd_ok;
  logic [DEPTH_LOG2-1:0] wr_idx, rd_idx;

  logic unused_ok;
  assign unused_ok = ^{AXI_AWPROT, AXI_ARPROT};

  assign AXI_AWREADY = ((state == IDLE) || (state == WR_COLLECT)) && !aw_got;
  assign AXI_WREADY  = ((state == IDLE) || (state == WR_COLLECT)) && !w_got;
  assign AXI_ARREADY = (state == IDLE) && !AXI_AWVALID && !AXI_WVALID;

  assign aw_hs = AXI_AWVALID && AXI_AWREADY;
  assign w_hs  = AXI_WVALID && AXI_WREADY;
  assign ar_hs = AXI_ARVALID && AXI_ARREADY;

  assign lat_zero = (lat_cnt == '0);
  assign commit   = (state == WR_LAT) && lat_zero;
  assign rd_done  = (state == RD_LAT) && lat_zero;

  // The subtraction wraps for addresses below the base, so both bounds are tested.
  assign wr_off = awaddr_q - BASE_ADDR;
  assign rd_off = araddr_q - BASE_ADDR;
  assign wr_ok  = (awaddr_q >= BASE_ADDR) && (wr_off < SPAN);
  assign rd_ok  = (araddr_q >= BASE_ADDR) && (rd_off < SPAN);
  assign wr_idx = DEPTH_LOG2'(wr_off >> LANE_BITS);
  assign rd_idx = DEPTH_LOG2'(rd_off >> LANE_BITS);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (aw_hs && w_hs)      state_next = WR_LAT;
        else if (aw_hs || w_hs) state_next = WR_COLLECT;
        else if (ar_hs)         state_next = RD_LAT;
      end
      WR_COLLECT: if ((aw_got || aw_hs) && (w_got || w_hs)) state_next = WR_LAT;
      WR_LAT:     if (lat_zero) state_next = WR_RESP;
      WR_RESP:    if (AXI_BREADY) state_next = IDLE;
      RD_LAT:     if (lat_zero) state_next = RD_RESP;
      RD_RESP:    if (AXI_RREADY) state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_got     <= 1'b0;
      w_got      <= 1'b0;
      lat_cnt    <= '0;
      AXI_BVALID <= 1'b0;
      AXI_BRESP  <= RESP_OKAY;
      AXI_RVALID <= 1'b0;
      AXI_RRESP  <= RESP_OKAY;
      AXI_RDATA  <= '0;
    end else begin
      if (aw_hs) begin
        aw_got   <= 1'b1;
        awaddr_q <= AXI_AWADDR;
      end
      if (w_hs) begin
        w_got   <= 1'b1;
        wdata_q <= AXI_WDATA;
        wstrb_q <= AXI_WSTRB;
      end
      if (ar_hs) araddr_q <= AXI_ARADDR;

      if ((state_next == WR_LAT) && (state != WR_LAT))
        lat_cnt <= CNT_W'(WR_LATENCY - 1);
      else if ((state_next == RD_LAT) && (state != RD_LAT))
        lat_cnt <= CNT_W'(RD_LATENCY - 1);
      else if (((state == WR_LAT) || (state == RD_LAT)) && !lat_zero)
        lat_cnt <= lat_cnt - 1'b1;

      if (commit) begin
        aw_got     <= 1'b0;
        w_got      <= 1'b0;
        AXI_BVALID <= 1'b1;
        AXI_BRESP  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      end
      if ((state == WR_RESP) && AXI_BREADY) AXI_BVALID <= 1'b0;

      if (rd_done) begin
        AXI_RVALID <= 1'b1;
        AXI_RDATA  <= rd_ok ? mem[rd_idx] : '0;
        AXI_RRESP  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
      end
      if ((state == RD_RESP) && AXI_RREADY) AXI_RVALID <= 1'b0;
    end
  end

  // RAM has no reset; a write landing on a reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (!rst && commit && wr_ok) begin
      for (int unsigned i = 0; i < STRB_W; i++) begin
        if (wstrb_q[i]) mem[wr_idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// Directed bench for axi_lite_mem_slave: vector table of single transactions
// followed by hand-written multi-cycle sequences.
module tb_axi_lite_mem_slave;

  localparam int unsigned RD_LAT = 2;
  localparam int unsigned WR_LAT = 1;
  localparam int LIMIT = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] AXI_AWADDR;
  logic [2:0]  AXI_AWPROT;
  logic        AXI_AWVALID;
  logic        AXI_AWREADY;
  logic [63:0] AXI_WDATA;
  logic [7:0]  AXI_WSTRB;
  logic        AXI_WVALID;
  logic        AXI_WREADY;
  logic [1:0]  AXI_BRESP;
  logic        AXI_BVALID;
  logic        AXI_BREADY;
  logic [31:0] AXI_ARADDR;
  logic [2:0]  AXI_ARPROT;
  logic        AXI_ARVALID;
  logic        AXI_ARREADY;
  logic [63:0] AXI_RDATA;
  logic [1:0]  AXI_RRESP;
  logic        AXI_RVALID;
  logic        AXI_RREADY;

  axi_lite_mem_slave #(
    .DATA_WIDTH(64),
    .ADDR_WIDTH(32),
    .DEPTH_LOG2(10),
    .BASE_ADDR (32'h8000_0000),
    .RD_LATENCY(RD_LAT),
    .WR_LATENCY(WR_LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .AXI_AWADDR (AXI_AWADDR),
    .AXI_AWPROT (AXI_AWPROT),
    .AXI_AWVALID(AXI_AWVALID),
    .AXI_AWREADY(AXI_AWREADY),
    .AXI_WDATA  (AXI_WDATA),
    .AXI_WSTRB  (AXI_WSTRB),
    .AXI_WVALID (AXI_WVALID),
    .AXI_WREADY (AXI_WREADY),
    .AXI_BRESP  (AXI_BRESP),
    .AXI_BVALID (AXI_BVALID),
    .AXI_BREADY (AXI_BREADY),
    .AXI_ARADDR (AXI_ARADDR),
    .AXI_ARPROT (AXI_ARPROT),
    .AXI_ARVALID(AXI_ARVALID),
    .AXI_ARREADY(AXI_ARREADY),
    .AXI_RDATA  (AXI_RDATA),
    .AXI_RRESP  (AXI_RRESP),
    .AXI_RVALID (AXI_RVALID),
    .AXI_RREADY (AXI_RREADY)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [63:0] data;   // write data, or expected read data
    logic [7:0]  strb;
    logic [1:0]  resp;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out after %0d cycles", name, LIMIT);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                          output logic [1:0] resp, output int lat);
    int n;
    AXI_AWADDR = a; AXI_WDATA = d; AXI_WSTRB = s;
    AXI_AWVALID = 1'b1; AXI_WVALID = 1'b1; AXI_BREADY = 1'b1;
    #1;
    n = 0;
    while (!(AXI_AWREADY && AXI_WREADY) && n < LIMIT) begin tick(); n++; end
    if (n >= LIMIT) timeout("write accept");
    tick();
    AXI_AWVALID = 1'b0; AXI_WVALID = 1'b0;
    lat = 0;
    while (!AXI_BVALID && lat < LIMIT) begin tick(); lat++; end
    resp = AXI_BRESP;
    tick();
    AXI_BREADY = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [63:0] d,
                         output logic [1:0] resp, output int lat);
    int n;
    AXI_ARADDR = a; AXI_ARVALID = 1'b1; AXI_RREADY = 1'b1;
    #1;
    n = 0;
    while (!AXI_ARREADY && n < LIMIT) begin tick(); n++; end
    if (n >= LIMIT) timeout("read accept");
    tick();
    AXI_ARVALID = 1'b0;
    lat = 0;
    while (!AXI_RVALID && lat < LIMIT) begin tick(); lat++; end
    d = AXI_RDATA;
    resp = AXI_RRESP;
    tick();
    AXI_RREADY = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  resp;
    logic [63:0] data;
    int          lat;
    int          n;

    vecs[0]  = '{1'b1, 32'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, 2'b00};
    vecs[1]  = '{1'b0, 32'h8000_0010, 64'h1122_3344_5566_7788, 8'h00, 2'b00};
    vecs[2]  = '{1'b1, 32'h8000_0010, 64'hFFFF_FFFF_AAAA_0000, 8'h0C, 2'b00};
    vecs[3]  = '{1'b0, 32'h8000_0010, 64'h1122_3344_AAAA_7788, 8'h00, 2'b00};
    vecs[4]  = '{1'b0, 32'h0000_1000, 64'h0,                   8'h00, 2'b10};
    vecs[5]  = '{1'b1, 32'h0000_1000, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 2'b10};
    vecs[6]  = '{1'b1, 32'h8000_2010, 64'hCAFE_CAFE_CAFE_CAFE, 8'hFF, 2'b10};
    vecs[7]  = '{1'b1, 32'h7FFF_FFF8, 64'h5555_5555_5555_5555, 8'hFF, 2'b10};
    vecs[8]  = '{1'b0, 32'h8000_0010, 64'h1122_3344_AAAA_7788, 8'h00, 2'b00};
    vecs[9]  = '{1'b1, 32'h8000_1FF8, 64'hA5A5_A5A5_5A5A_5A5A, 8'hFF, 2'b00};
    vecs[10] = '{1'b0, 32'h8000_1FFF, 64'hA5A5_A5A5_5A5A_5A5A, 8'h00, 2'b00};
    vecs[11] = '{1'b0, 32'h8000_2000, 64'h0,                   8'h00, 2'b10};
    vecs[12] = '{1'b1, 32'h8000_0023, 64'h0F0E_0D0C_0B0A_0908, 8'hFF, 2'b00};
    vecs[13] = '{1'b0, 32'h8000_0020, 64'h0F0E_0D0C_0B0A_0908, 8'h00, 2'b00};

    rst = 1'b1;
    AXI_AWADDR = '0; AXI_AWPROT = '0; AXI_AWVALID = 1'b0;
    AXI_WDATA = '0; AXI_WSTRB = '0; AXI_WVALID = 1'b0; AXI_BREADY = 1'b0;
    AXI_ARADDR = '0; AXI_ARPROT = '0; AXI_ARVALID = 1'b0; AXI_RREADY = 1'b0;
    tick(); tick(); tick();
    rst = 1'b0;
    #1;
    check("reset BVALID", AXI_BVALID, 1'b0);
    check("reset RVALID", AXI_RVALID, 1'b0);
    check("reset BRESP", AXI_BRESP, 2'b00);
    check("reset RRESP", AXI_RRESP, 2'b00);
    check("reset RDATA", AXI_RDATA, 64'h0);
    check("reset AWREADY", AXI_AWREADY, 1'b1);
    check("reset WREADY", AXI_WREADY, 1'b1);
    check("reset ARREADY", AXI_ARREADY, 1'b1);

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].wr) begin
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp, lat);
        check($sformatf("v%0d BRESP", i), resp, vecs[i].resp);
        check($sformatf("v%0d B latency", i), lat, WR_LAT);
      end else begin
        do_read(vecs[i].addr, data, resp, lat);
        check($sformatf("v%0d RRESP", i), resp, vecs[i].resp);
        check($sformatf("v%0d RDATA", i), data, vecs[i].data);
        check($sformatf("v%0d R latency", i), lat, RD_LAT);
      end
      check($sformatf("v%0d idle AWREADY", i), AXI_AWREADY, 1'b1);
      check($sformatf("v%0d idle ARREADY", i), AXI_ARREADY, 1'b1);
    end

    // W arrives alone and waits several cycles before AW
    AXI_WDATA = 64'h1357_9BDF_2468_ACE0; AXI_WSTRB = 8'hFF;
    AXI_WVALID = 1'b1; AXI_BREADY = 1'b1;
    #1;
    check("wfirst WREADY", AXI_WREADY, 1'b1);
    check("wfirst ARREADY", AXI_ARREADY, 1'b0);
    tick();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("wfirst hold%0d WREADY", k), AXI_WREADY, 1'b0);
      check($sformatf("wfirst hold%0d AWREADY", k), AXI_AWREADY, 1'b1);
      tick();
    end
    AXI_WVALID = 1'b0; AXI_WDATA = 64'hBADB_ADBA_DBAD_BADB;
    AXI_AWADDR = 32'h8000_0040; AXI_AWVALID = 1'b1;
    #1;
    check("wfirst AWREADY", AXI_AWREADY, 1'b1);
    tick();
    AXI_AWVALID = 1'b0;
    lat = 0;
    while (!AXI_BVALID && lat < LIMIT) begin tick(); lat++; end
    check("wfirst B latency", lat, WR_LAT);
    check("wfirst BRESP", AXI_BRESP, 2'b00);
    tick();
    AXI_BREADY = 1'b0;
    do_read(32'h8000_0040, data, resp, lat);
    check("wfirst readback", data, 64'h1357_9BDF_2468_ACE0);

    // Read response held under backpressure
    AXI_ARADDR = 32'h8000_0040; AXI_ARVALID = 1'b1; AXI_RREADY = 1'b0;
    #1;
    n = 0;
    while (!AXI_ARREADY && n < LIMIT) begin tick(); n++; end
    if (n >= LIMIT) timeout("bp read accept");
    tick();
    AXI_ARVALID = 1'b0;
    lat = 0;
    while (!AXI_RVALID && lat < LIMIT) begin tick(); lat++; end
    check("bp R latency", lat, RD_LAT);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("bp%0d RVALID", k), AXI_RVALID, 1'b1);
      check($sformatf("bp%0d RDATA", k), AXI_RDATA, 64'h1357_9BDF_2468_ACE0);
      check($sformatf("bp%0d ARREADY", k), AXI_ARREADY, 1'b0);
      tick();
    end
    AXI_RREADY = 1'b1;
    tick();
    check("bp released RVALID", AXI_RVALID, 1'b0);
    check("bp released ARREADY", AXI_ARREADY, 1'b1);
    AXI_RREADY = 1'b0;

    // AR competing with AW+W: write wins, read follows and sees new data
    AXI_AWADDR = 32'h8000_0080; AXI_WDATA = 64'h0123_4567_89AB_CDEF; AXI_WSTRB = 8'hFF;
    AXI_ARADDR = 32'h8000_0080;
    AXI_AWVALID = 1'b1; AXI_WVALID = 1'b1; AXI_ARVALID = 1'b1;
    AXI_BREADY = 1'b1; AXI_RREADY = 1'b1;
    #1;
    check("prio ARREADY", AXI_ARREADY, 1'b0);
    check("prio AWREADY", AXI_AWREADY, 1'b1);
    check("prio WREADY", AXI_WREADY, 1'b1);
    tick();
    AXI_AWVALID = 1'b0; AXI_WVALID = 1'b0;
    check("prio ARREADY in write", AXI_ARREADY, 1'b0);
    lat = 0;
    while (!AXI_BVALID && lat < LIMIT) begin tick(); lat++; end
    check("prio B latency", lat, WR_LAT);
    check("prio ARREADY at B", AXI_ARREADY, 1'b0);
    tick();
    check("prio ARREADY after B", AXI_ARREADY, 1'b1);
    tick();
    AXI_ARVALID = 1'b0;
    lat = 0;
    while (!AXI_RVALID && lat < LIMIT) begin tick(); lat++; end
    check("prio R latency", lat, RD_LAT);
    check("prio RDATA", AXI_RDATA, 64'h0123_4567_89AB_CDEF);
    tick();
    AXI_RREADY = 1'b0; AXI_BREADY = 1'b0;

    // Reset while the write is pending: RAM must keep its old word
    AXI_AWADDR = 32'h8000_0010; AXI_WDATA = 64'hBAD0_BAD0_BAD0_BAD0; AXI_WSTRB = 8'hFF;
    AXI_AWVALID = 1'b1; AXI_WVALID = 1'b1; AXI_BREADY = 1'b1;
    #1;
    tick();
    AXI_AWVALID = 1'b0; AXI_WVALID = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("wr reset BVALID", AXI_BVALID, 1'b0);
    tick();
    check("wr reset BVALID later", AXI_BVALID, 1'b0);
    AXI_BREADY = 1'b0;
    do_read(32'h8000_0010, data, resp, lat);
    check("wr reset RAM kept", data, 64'h1122_3344_AAAA_7788);

    // Reset during read latency: no response, back to idle
    AXI_ARADDR = 32'h8000_0010; AXI_ARVALID = 1'b1; AXI_RREADY = 1'b1;
    #1;
    tick();
    AXI_ARVALID = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rd reset RVALID", AXI_RVALID, 1'b0);
    check("rd reset AWREADY", AXI_AWREADY, 1'b1);
    check("rd reset WREADY", AXI_WREADY, 1'b1);
    check("rd reset ARREADY", AXI_ARREADY, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("rd reset RVALID +%0d", k + 1), AXI_RVALID, 1'b0);
    end
    AXI_RREADY = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_lite_mem_slave.md
Name: axi_lite_mem_slave

Overview:
- AXI4-Lite responder with an internal 64-bit-wide, byte-strobed RAM. It is the subordinate end of the LSU's AXI4-Lite data port.
- Accepts single-beat reads and writes and returns responses after a parameterised latency, so LSU handshake timing can be exercised.
- Serves one transaction at a time. Out-of-range addresses are answered with SLVERR.

Parameters:
- DATA_WIDTH, 64, data bus width in bits; the strobe is DATA_WIDTH/8 bits.
- ADDR_WIDTH, 32, address bus width in bits.
- DEPTH_LOG2, 10, log2 of the number of RAM words.
- BASE_ADDR, 32'h8000_0000, byte address of word 0.
- RD_LATENCY, 2, cycles from the AR handshake edge to RVALID high. Must be ≥1.
- WR_LATENCY, 1, cycles from the last AW/W handshake edge to BVALID high. Must be ≥1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- AXI_AWADDR  in  ADDR_WIDTH  write address
- AXI_AWPROT  in  3  ignored
- AXI_AWVALID  in  1
- AXI_AWREADY  out  1
- AXI_WDATA  in  DATA_WIDTH
- AXI_WSTRB  in  DATA_WIDTH/8  byte enables
- AXI_WVALID  in  1
- AXI_WREADY  out  1
- AXI_BRESP  out  2  2'b00 OKAY, 2'b10 SLVERR
- AXI_BVALID  out  1
- AXI_BREADY  in  1
- AXI_ARADDR  in  ADDR_WIDTH
- AXI_ARPROT  in  3  ignored
- AXI_ARVALID  in  1
- AXI_ARREADY  out  1
- AXI_RDATA  out  DATA_WIDTH
- AXI_RRESP  out  2
- AXI_RVALID  out  1
- AXI_RREADY  in  1

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, BVALID=0, RVALID=0, BRESP=0, RRESP=0, RDATA=0, aw_got=0, w_got=0. RAM contents are not reset.
- State machine states: IDLE, WR_COLLECT, WR_LAT, WR_RESP, RD_LAT, RD_RESP.
- Ready signals (combinational from state/flags):
  - AWREADY = (IDLE|WR_COLLECT) & !aw_got.
  - WREADY = (IDLE|WR_COLLECT) & !w_got.
  - ARREADY = IDLE & !AWVALID & !WVALID. Writes have priority; with no VALIDs, all three readies are 1 after reset.
- IDLE transitions:
  - AW and W handshake in the same cycle: go to WR_LAT.
  - Only one of AW/W handshakes: latch it, set the matching flag, go to WR_COLLECT.
  - Else AR handshake: latch ARADDR, go to RD_LAT.
- WR_COLLECT: wait for the missing half of the write, then go to WR_LAT. Either order is legal. Captured address and data are held in registers.
- Latency counter: loaded with (LATENCY-1) on entry to WR_LAT/RD_LAT and decremented each cycle; exit when it reaches 0. LATENCY=1 means VALID is high on the cycle after the handshake edge.
- Write commit, on leaving WR_LAT:
  - Update bytes where WSTRB[i]=1; other bytes are unchanged.
  - Set BVALID=1 and BRESP per address decode.
  - Clear both flags.
- WR_RESP: hold BVALID and BRESP until BVALID&BREADY, then go to IDLE.
- Read sample, on leaving RD_LAT:
  - In range: RDATA = RAM word.
  - Out of range: RDATA = 0, RRESP = 2'b10.
- RD_RESP: hold RVALID, RDATA and RRESP stable while RREADY=0. On handshake go to IDLE; RVALID drops the next cycle.
- Address decode:
  - off = addr - BASE_ADDR.
  - In range iff addr ≥ BASE_ADDR and off < 2^DEPTH_LOG2 * 8.
  - Word index = off >> 3; addr[2:0] is ignored (lanes are selected by WSTRB).
  - Out-of-range write: discarded, BRESP = 2'b10.
- Ordering: a write commits before its BVALID, so a following read returns the new data.
- Reset mid-operation: any pending transaction is dropped with no B/R response. An uncommitted write does not modify the RAM.
- Back-to-back transactions: no bubble beyond the return to IDLE. The cycle after a B or R handshake, readies reflect IDLE.

Test Plan:
- Full write: AW=0x8000_0010, W=0x1122334455667788, WSTRB=0xFF, same cycle, BREADY=1 -> BVALID 1 cycle after the handshake, BRESP=00. Then AR=0x8000_0010 -> RVALID 2 cycles after the AR handshake, RDATA=0x1122334455667788, RRESP=00.
- Partial write: WSTRB=0x0C, WDATA=0xFFFFFFFFAAAA0000 to the same address -> readback 0x11223344AAAA7788.
- W before AW: WVALID alone for 3 cycles, then AWVALID -> WREADY low after the W handshake while AWREADY stays 1; BVALID WR_LATENCY cycles after the AW handshake; data committed.
- Backpressure: hold RREADY=0 for 4 cycles during RD_RESP -> RVALID and RDATA stable, ARREADY=0; release -> RVALID low the next cycle.
- Out of range: read 0x0000_1000 -> RRESP=10, RDATA=0. Write to the same address -> BRESP=10, RAM unchanged.
- Simultaneous AR and AW+W in IDLE -> write served first, ARREADY=0 until back in IDLE. Reset asserted in RD_LAT -> no RVALID, state IDLE, readies 1.
